operand_stage: RTL and testbench

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/alu_pkg.sv | 22 ++
 rtl/regfile.sv | 44 ++++
 rtl/operand_stage.sv | 126 ++++++++++++
 tb/tb_operand_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and default datapath widths
// used by the operand stage and its register file.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_ADDR_W = 5;
  localparam int IMM_W      = 16;
  localparam int SEL_W      = 4;

  typedef enum logic [SEL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_MUL = 4'b0011,
    ALU_DIV = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000
  } alu_op_e;

endpackage

// File: rtl/regfile.sv
// Register file with two asynchronous read ports and one synchronous write
// port; register 0 is hard-wired to zero and reset clears every entry.
module regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int ADDR_W = ALU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != '0)) begin
      regs_d[wa] = wd;
    end
  end

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs_q[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs_q[rb_addr];

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: reads the register file, selects OP2 and registers the
// ALU operands. Define OPERAND_BYPASS_EN to forward same-cycle write-back data.
module operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int ADDR_W = ALU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [15:0]       imm,
  input  logic              alu_src,
  input  logic              sign_ext,
  input  logic [3:0]        sel_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] OP1,
  output logic [DATA_W-1:0] OP2,
  output logic [3:0]        sel,
  output logic [DATA_W-1:0] rt_data
);

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm_i,
                                                input logic             sext);
    logic signed [IMM_W-1:0]  imm_s;
    logic signed [DATA_W-1:0] wide_s;
    imm_s  = imm_i;
    wide_s = DATA_W'(imm_s);
    return sext ? wide_s : {{(DATA_W-IMM_W){1'b0}}, imm_i};
  endfunction

  logic [DATA_W-1:0] rs_rdata;
  logic [DATA_W-1:0] rt_rdata;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs_addr),
    .ra_data (rs_rdata),
    .rb_addr (rt_addr),
    .rb_data (rt_rdata),
    .we      (we),
    .wa      (wa),
    .wd      (wd)
  );

  always_comb begin
    rs_val = rs_rdata;
    rt_val = rt_rdata;
`ifdef OPERAND_BYPASS_EN
    if (we && (wa != '0) && (wa == rs_addr)) begin
      rs_val = wd;
    end
    if (we && (wa != '0) && (wa == rt_addr)) begin
      rt_val = wd;
    end
`endif
  end

  logic              vld_p1_q;
  logic              vld_p1_d;
  logic [DATA_W-1:0] op1_p1_q;
  logic [DATA_W-1:0] op1_p1_d;
  logic [DATA_W-1:0] op2_p1_q;
  logic [DATA_W-1:0] op2_p1_d;
  logic [DATA_W-1:0] rtd_p1_q;
  logic [DATA_W-1:0] rtd_p1_d;
  logic [3:0]        sel_p1_q;
  logic [3:0]        sel_p1_d;

  // ID -> EX boundary: flush beats stall, stall beats a new capture.
  always_comb begin
    vld_p1_d = vld_p1_q;
    op1_p1_d = op1_p1_q;
    op2_p1_d = op2_p1_q;
    rtd_p1_d = rtd_p1_q;
    sel_p1_d = sel_p1_q;
    if (flush) begin
      vld_p1_d = 1'b0;
      sel_p1_d = ALU_AND;
    end else if (!stall) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        op1_p1_d = rs_val;
        op2_p1_d = alu_src ? ext_imm(imm, sign_ext) : rt_val;
        rtd_p1_d = rt_val;
        sel_p1_d = sel_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      op1_p1_q <= '0;
      op2_p1_q <= '0;
      rtd_p1_q <= '0;
      sel_p1_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      op1_p1_q <= op1_p1_d;
      op2_p1_q <= op2_p1_d;
      rtd_p1_q <= rtd_p1_d;
      sel_p1_q <= sel_p1_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign OP1       = op1_p1_q;
  assign OP2       = op2_p1_q;
  assign sel       = sel_p1_q;
  assign rt_data   = rtd_p1_q;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed scenarios plus random traffic
// checked against a register-array reference model.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] imm;
  logic        alu_src;
  logic        sign_ext;
  logic [3:0]  sel_in;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  sel;
  logic [31:0] rt_data;

  always #5 clk = ~clk;

  operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .imm       (imm),
    .alu_src   (alu_src),
    .sign_ext  (sign_ext),
    .sel_in    (sel_in),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .OP1       (op1),
    .OP2       (op2),
    .sel       (sel),
    .rt_data   (rt_data)
  );

`ifdef OPERAND_BYPASS_EN
  localparam logic [31:0] SAME_CYCLE_EXP = 32'h1234_5678;
`else
  localparam logic [31:0] SAME_CYCLE_EXP = 32'h0000_0000;
`endif

  typedef struct {
    logic        vld;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rtd;
    logic [3:0]  sel;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_out;
  logic [31:0] m_regs[32];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sx);
    if (sx && (v >= 16'h8000)) return 32'(v) - 32'h0001_0000;
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef OPERAND_BYPASS_EN
    if (we && (wa == a)) return wd;
`endif
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  // Advance the model for the current inputs, queue the expectation, clock.
  task automatic step();
    exp_t n;
    n = m_out;
    if (rst) begin
      n.vld = 1'b0; n.op1 = '0; n.op2 = '0; n.rtd = '0; n.sel = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      if (flush) begin
        n.vld = 1'b0;
        n.sel = 4'b0000;
      end else if (!stall) begin
        n.vld = in_valid;
        if (in_valid) begin
          n.op1 = model_read(rs_addr);
          n.rtd = model_read(rt_addr);
          n.op2 = alu_src ? ext16(imm, sign_ext) : model_read(rt_addr);
          n.sel = sel_in;
        end
      end
      if (we && (wa != 5'd0)) m_regs[wa] = wd;
    end
    m_out = n;
    exp_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; rs_addr = 0; rt_addr = 0; imm = 0; alu_src = 0;
    sign_ext = 0; sel_in = 0; we = 0; wa = 0; wd = 0; stall = 0; flush = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid === e.vld && op1 === e.op1 && op2 === e.op2 &&
          rt_data === e.rtd && sel === e.sel) begin
        n_pass++;
      end else begin
        $display("FAIL scoreboard: got vld=%b op1=%h op2=%h rt=%h sel=%h want vld=%b op1=%h op2=%h rt=%h sel=%h",
                 out_valid, op1, op2, rt_data, sel, e.vld, e.op1, e.op2, e.rtd, e.sel);
      end
    end
  end

  initial begin
    m_out.vld = 0; m_out.op1 = 0; m_out.op2 = 0; m_out.rtd = 0; m_out.sel = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;

    idle(); rst = 1;
    step(); step();
    chk("reset_vld", 32'(out_valid), 32'h0);
    chk("reset_op1", op1, 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);

    // Same-cycle write and read of R[5].
    idle(); we = 1; wa = 5; wd = 32'h1234_5678; in_valid = 1; rs_addr = 5; sel_in = 4'b0010;
    step();
    chk("same_cycle_op1", op1, SAME_CYCLE_EXP);
    idle(); in_valid = 1; rs_addr = 5;
    step();
    chk("write_landed_op1", op1, 32'h1234_5678);

    // R[3]=5, R[4]=7, then ADD operands.
    idle(); we = 1; wa = 3; wd = 32'h5; step();
    idle(); we = 1; wa = 4; wd = 32'h7; step();
    idle(); in_valid = 1; rs_addr = 3; rt_addr = 4; sel_in = 4'b0010;
    step();
    chk("add_vld", 32'(out_valid), 32'h1);
    chk("add_op1", op1, 32'h5);
    chk("add_op2", op2, 32'h7);
    chk("add_sel", 32'(sel), 32'h2);

    idle(); in_valid = 1; imm = 16'hFFF0; alu_src = 1; sign_ext = 1;
    step();
    chk("imm_sext", op2, 32'hFFFF_FFF0);
    sign_ext = 0;
    step();
    chk("imm_zext", op2, 32'h0000_FFF0);

    idle(); we = 1; wa = 0; wd = 32'hDEAD_BEEF; step();
    idle(); in_valid = 1; rs_addr = 0; step();
    chk("r0_reads_zero", op1, 32'h0);

    // Freeze under stall, then flush overrides stall.
    idle(); in_valid = 1; rs_addr = 3; rt_addr = 4; sel_in = 4'b0110; step();
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; in_valid = 1; rs_addr = 5'(i + 5); rt_addr = 5'(i + 1);
      sel_in = 4'(i + 1); alu_src = 1; imm = 16'(i * 300);
      step();
      chk("stall_vld", 32'(out_valid), 32'h1);
      chk("stall_op1", op1, 32'h5);
      chk("stall_op2", op2, 32'h7);
      chk("stall_sel", 32'(sel), 32'h6);
    end
    idle(); stall = 1; flush = 1; in_valid = 1; sel_in = 4'b0011; step();
    chk("flush_vld", 32'(out_valid), 32'h0);
    chk("flush_sel", 32'(sel), 32'h0);

    // Reset mid-stream discards the simultaneous write.
    idle(); we = 1; wa = 2; wd = 32'h55; step();
    idle(); rst = 1; we = 1; wa = 2; wd = 32'hFF; in_valid = 1; rs_addr = 2; sel_in = 4'b0111;
    step();
    chk("rst_vld", 32'(out_valid), 32'h0);
    chk("rst_op1", op1, 32'h0);
    chk("rst_op2", op2, 32'h0);
    chk("rst_rt", rt_data, 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    idle(); in_valid = 1; rs_addr = 2; rt_addr = 2; step();
    chk("post_rst_vld", 32'(out_valid), 32'h1);
    chk("post_rst_r2", op1, 32'h0);
    chk("post_rst_rt", rt_data, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(63) == 0);
      in_valid = $urandom_range(1);
      rs_addr  = 5'($urandom_range(7));
      rt_addr  = 5'($urandom_range(7));
      imm      = 16'($urandom);
      alu_src  = $urandom_range(1);
      sign_ext = $urandom_range(1);
      sel_in   = 4'($urandom_range(8));
      we       = $urandom_range(1);
      wa       = 5'($urandom_range(7));
      wd       = $urandom;
      stall    = ($urandom_range(4) == 0);
      flush    = ($urandom_range(9) == 0);
      step();
    end

    idle();
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
